// File: rtl/piece_draw_scheduler.sv
// piece_draw_scheduler: square tracking, board state, shared sprite ROM
// sequencing and vblank-committed board updates. Option: PIECE_CHECK_BORDER_EN.
module piece_draw_scheduler #(
    parameter int SQ         = 60,
    parameter int BOARD_X    = 80,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [5:0]  upd_square,
    input  logic [3:0]  upd_piece,
    input  logic        sel_en,
    input  logic [5:0]  sel_square,
    input  logic        chk_en,
    input  logic [5:0]  chk_square,
    output logic [15:0] rom_addr,
    input  logic [3:0]  rom_q,
    output logic [3:0]  pal_index,
    input  logic [11:0] pal_rgb,
    output logic        piece_on,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [9:0]  SQW  = 10'(SQ);
    localparam logic [9:0]  XLO  = 10'(BOARD_X);
    localparam logic [9:0]  XOFF = 10'(BOARD_X + 1);
    localparam logic [9:0]  YHI  = 10'(8 * SQ);
    localparam logic [15:0] SQ16 = 16'(SQ);
    localparam logic [15:0] SQ2  = 16'(SQ * SQ);

    typedef enum logic {ACTIVE, DRAIN} state_t;

    function automatic logic [3:0] opening(input logic [5:0] sq);
        logic [3:0] rank;
        case (sq[2:0])
            3'd0, 3'd7: rank = 4'd4;
            3'd1, 3'd6: rank = 4'd2;
            3'd2, 3'd5: rank = 4'd3;
            3'd3:       rank = 4'd5;
            default:    rank = 4'd6;
        endcase
        case (sq[5:3])
            3'd0:    return rank | 4'd8;
            3'd1:    return 4'd9;
            3'd6:    return 4'd1;
            3'd7:    return rank;
            default: return 4'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [9:0]  mem_q [FIFO_DEPTH];
    logic [9:0]  mem_d [FIFO_DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [3:0]  board_q [64];
    logic [3:0]  board_d [64];
    logic        sel_en_q, sel_en_d;
    logic [5:0]  sel_sq_q, sel_sq_d;
`ifdef PIECE_CHECK_BORDER_EN
    logic        chk_en_q, chk_en_d;
    logic [5:0]  chk_sq_q, chk_sq_d;
    logic        s1_bdr_q, s1_bdr_d, s2_bdr_q;
`else
    logic        unused_chk;
    assign unused_chk = ^{chk_en, chk_square};
`endif

    logic        s0_vis_q, s0_vis_d;
    logic [5:0]  s0_sq_q, s0_sq_d;
    logic [9:0]  s0_lx_q, s0_lx_d, s0_ly_q, s0_ly_d;
    logic [3:0]  s0_pc_q, s0_pc_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic        s1_occ_q, s1_occ_d, s1_sel_q, s1_sel_d;
    logic        s1_vis_q, s1_vis_d;
    logic        s2_occ_q, s2_sel_q, s2_vis_q;

    logic        vblank, full, empty, push, pop, capture;
    logic [9:0]  head;

    // Vblank FSM, FIFO pointers and the drain write into the board.
    always_comb begin
        vblank  = DrawY >= YHI;
        empty   = wr_q == rd_q;
        full    = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
        push    = upd_valid && !full;
        pop     = (state_q == DRAIN) && vblank && !empty;
        capture = (state_q == ACTIVE) && vblank;
        state_d = vblank ? DRAIN : ACTIVE;
        head    = mem_q[rd_q[AW-1:0]];
        mem_d   = mem_q;
        board_d = board_q;
        if (push) mem_d[wr_q[AW-1:0]] = {upd_square, upd_piece};
        if (pop) board_d[head[9:4]] = head[3:0];
        wr_d = wr_q + {{AW{1'b0}}, push};
        rd_d = rd_q + {{AW{1'b0}}, pop};
    end

    // Highlight requests are frozen at the start of vblank for a whole frame.
    always_comb begin
        sel_en_d = sel_en_q;
        sel_sq_d = sel_sq_q;
        if (capture) begin
            sel_en_d = sel_en;
            sel_sq_d = sel_square;
        end
`ifdef PIECE_CHECK_BORDER_EN
        chk_en_d = chk_en_q;
        chk_sq_d = chk_sq_q;
        if (capture) begin
            chk_en_d = chk_en;
            chk_sq_d = chk_square;
        end
`endif
    end

    logic [9:0] dx, col, row, lx, ly;

    // S0: locate the raster within the board and fetch the square's piece.
    always_comb begin
        dx       = DrawX - XOFF;
        col      = dx / SQW;
        lx       = dx - col * SQW;
        row      = DrawY / SQW;
        ly       = DrawY - row * SQW;
        s0_vis_d = blank && (DrawX > XLO) &&
                   (col < 10'd8) && (row < 10'd8);
        s0_sq_d  = {row[2:0], col[2:0]};
        s0_lx_d  = lx;
        s0_ly_d  = ly;
        s0_pc_d  = board_q[s0_sq_d];
    end

    logic [3:0] idx;

    // S1: sprite ROM address and per-pixel flags.
    always_comb begin
        idx        = (s0_pc_q[3] ? 4'd6 : 4'd0) +
                     {1'b0, s0_pc_q[2:0]} - 4'd1;
        rom_addr_d = 16'(idx) * SQ2 + 16'(s0_ly_q) * SQ16 +
                     16'(s0_lx_q);
        s1_occ_d   = (s0_pc_q[2:0] != 3'd0) && (s0_pc_q[2:0] != 3'd7);
        s1_sel_d   = sel_en_q && (s0_sq_q == sel_sq_q);
        s1_vis_d   = s0_vis_q;
`ifdef PIECE_CHECK_BORDER_EN
        s1_bdr_d   = chk_en_q && (s0_sq_q == chk_sq_q) &&
                     ((s0_lx_q < 10'd5) || (s0_lx_q >= SQW - 10'd5) ||
                      (s0_ly_q < 10'd5) || (s0_ly_q >= SQW - 10'd5));
`endif
    end

    // State, FIFO, board and pipeline registers.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= ACTIVE;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            for (int i = 0; i < 64; i++) board_q[i] <= opening(6'(i));
            sel_en_q   <= 1'b0;
            sel_sq_q   <= '0;
            s0_vis_q   <= 1'b0;
            s0_sq_q    <= '0;
            s0_lx_q    <= '0;
            s0_ly_q    <= '0;
            s0_pc_q    <= '0;
            rom_addr_q <= '0;
            s1_occ_q   <= 1'b0;
            s1_sel_q   <= 1'b0;
            s1_vis_q   <= 1'b0;
            s2_occ_q   <= 1'b0;
            s2_sel_q   <= 1'b0;
            s2_vis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            mem_q      <= mem_d;
            board_q    <= board_d;
            sel_en_q   <= sel_en_d;
            sel_sq_q   <= sel_sq_d;
            s0_vis_q   <= s0_vis_d;
            s0_sq_q    <= s0_sq_d;
            s0_lx_q    <= s0_lx_d;
            s0_ly_q    <= s0_ly_d;
            s0_pc_q    <= s0_pc_d;
            rom_addr_q <= rom_addr_d;
            s1_occ_q   <= s1_occ_d;
            s1_sel_q   <= s1_sel_d;
            s1_vis_q   <= s1_vis_d;
            s2_occ_q   <= s1_occ_q;
            s2_sel_q   <= s1_sel_q;
            s2_vis_q   <= s1_vis_q;
        end
    end

`ifdef PIECE_CHECK_BORDER_EN
    // Checked-king border shadow and its pipeline flags.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            chk_en_q <= 1'b0;
            chk_sq_q <= '0;
            s1_bdr_q <= 1'b0;
            s2_bdr_q <= 1'b0;
        end else begin
            chk_en_q <= chk_en_d;
            chk_sq_q <= chk_sq_d;
            s1_bdr_q <= s1_bdr_d;
            s2_bdr_q <= s1_bdr_q;
        end
    end
`endif

    logic        bdr_hit;
    logic [11:0] rgb;

    // S2: priority mux of border, sprite and highlight colours.
    always_comb begin
`ifdef PIECE_CHECK_BORDER_EN
        bdr_hit = s2_bdr_q;
`else
        bdr_hit = 1'b0;
`endif
        pal_index = s2_vis_q ? rom_q : 4'd0;
        piece_on  = 1'b0;
        rgb       = 12'h000;
        if (s2_vis_q) begin
            if (bdr_hit) begin
                piece_on = 1'b1;
                rgb      = 12'hF00;
            end else if (s2_occ_q && (rom_q != 4'd0)) begin
                piece_on = 1'b1;
                rgb      = pal_rgb;
            end else if (s2_sel_q) begin
                piece_on = 1'b1;
                rgb      = 12'h6A6;
            end
        end
        {red, green, blue} = rgb;
        rom_addr  = rom_addr_q;
        upd_ready = !full;
    end

endmodule

// File: tb/tb_piece_draw_scheduler.sv
// tb_piece_draw_scheduler: scoreboard bench with a reference board model,
// synchronous sprite ROM model and combinational palette model.
module tb_piece_draw_scheduler;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic        upd_valid, upd_ready;
    logic [5:0]  upd_square;
    logic [3:0]  upd_piece;
    logic        sel_en, chk_en;
    logic [5:0]  sel_square, chk_square;
    logic [15:0] rom_addr;
    logic [3:0]  rom_q, pal_index;
    logic [11:0] pal_rgb;
    logic        piece_on;
    logic [3:0]  red, green, blue;

    piece_draw_scheduler dut (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_square(upd_square), .upd_piece(upd_piece),
        .sel_en(sel_en), .sel_square(sel_square),
        .chk_en(chk_en), .chk_square(chk_square),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .pal_index(pal_index), .pal_rgb(pal_rgb),
        .piece_on(piece_on),
        .red(red), .green(green), .blue(blue)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [3:0] romf(input logic [15:0] a);
        if (a[2:0] == 3'd0) return 4'd0;
        return a[3:0] ^ a[9:6];
    endfunction

    function automatic logic [11:0] palf(input logic [3:0] i);
        return {i, ~i, i ^ 4'h5};
    endfunction

    always_ff @(posedge vga_clk) rom_q <= romf(rom_addr);
    assign pal_rgb = palf(pal_index);

    typedef struct { int due; logic on; logic [11:0] rgb; } oexp_t;
    typedef struct { int due; logic [15:0] a; } aexp_t;
    oexp_t oq[$];
    aexp_t aq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [3:0] bm [64];
    logic [9:0] mq [$];
    bit         mdrain;
    bit         msel_en, mchk_en;
    logic [5:0] msel_sq, mchk_sq;
    logic [3:0] back [8] = '{4'd4, 4'd2, 4'd3, 4'd5,
                             4'd6, 4'd3, 4'd2, 4'd4};

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 64; i++) bm[i] = 4'd0;
        for (int c = 0; c < 8; c++) begin
            bm[c]      = back[c] | 4'd8;
            bm[8 + c]  = 4'd9;
            bm[48 + c] = 4'd1;
            bm[56 + c] = back[c];
        end
        mq.delete();
        mdrain  = 1'b0;
        msel_en = 1'b0;
        mchk_en = 1'b0;
        msel_sq = '0;
        mchk_sq = '0;
        oq.delete();
        aq.delete();
    endtask

    task automatic exp_pix(input int x, input int y, input logic bl,
                           output logic on, output logic [11:0] rgb,
                           output logic has_a, output logic [15:0] a);
        int dx, c, r, lx, ly, sq, idx;
        logic [3:0] code, q;
        logic occ, bdr;
        on = 1'b0; rgb = 12'h0; has_a = 1'b0; a = 16'h0;
        if (!(x > 80 && x <= 560 && y < 480)) return;
        dx = x - 81; c = dx / 60; lx = dx % 60;
        r = y / 60; ly = y % 60; sq = r * 8 + c;
        code = bm[sq];
        occ = (code >= 4'd1 && code <= 4'd6) ||
              (code >= 4'd9 && code <= 4'd14);
        idx = (code >= 4'd9) ? int'(code) - 3 : int'(code) - 1;
        a = 16'(idx * 3600 + ly * 60 + lx);
        has_a = occ;
        if (!bl) return;
        q = romf(a);
`ifdef PIECE_CHECK_BORDER_EN
        bdr = mchk_en && (6'(sq) == mchk_sq) &&
              (lx < 5 || lx >= 55 || ly < 5 || ly >= 55);
`else
        bdr = 1'b0;
`endif
        if (bdr) begin
            on = 1'b1; rgb = 12'hF00;
        end else if (occ && q != 4'd0) begin
            on = 1'b1; rgb = palf(q);
        end else if (msel_en && 6'(sq) == msel_sq) begin
            on = 1'b1; rgb = 12'h6A6;
        end
    endtask

    task automatic step(input int x, input int y, input logic bl);
        oexp_t oe;
        aexp_t ae;
        logic has_a, fire, vb;
        logic [9:0] e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = bl;
        fire  = 1'b0;
        if (!reset) begin
            exp_pix(x, y, bl, oe.on, oe.rgb, has_a, ae.a);
            oe.due = cyc + 3;
            ae.due = cyc + 2;
            oq.push_back(oe);
            if (has_a) aq.push_back(ae);
            check_eq("upd_ready", 32'(upd_ready), 32'(mq.size() < 4));
            fire = upd_valid && (mq.size() < 4);
        end
        @(posedge vga_clk);
        cyc++;
        if (reset) begin
            m_reset();
        end else begin
            vb = (y >= 480);
            if (mdrain && vb && mq.size() > 0) begin
                e = mq.pop_front();
                bm[e[9:4]] = e[3:0];
            end
            if (fire) mq.push_back({upd_square, upd_piece});
            if (!mdrain && vb) begin
                msel_en = sel_en; msel_sq = sel_square;
                mchk_en = chk_en; mchk_sq = chk_square;
            end
            mdrain = vb;
        end
        #1;
        if (oq.size() > 0 && oq[0].due == cyc) begin
            oe = oq.pop_front();
            check_eq("piece_on", 32'(piece_on), 32'(oe.on));
            check_eq("rgb", 32'({red, green, blue}), 32'(oe.rgb));
        end
        if (aq.size() > 0 && aq[0].due == cyc) begin
            ae = aq.pop_front();
            check_eq("rom_addr", 32'(rom_addr), 32'(ae.a));
        end
    endtask

    task automatic reset_checks();
        check_eq("rst_piece_on", 32'(piece_on), 32'd0);
        check_eq("rst_rgb", 32'({red, green, blue}), 32'd0);
        check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
        check_eq("rst_pal_index", 32'(pal_index), 32'd0);
        check_eq("rst_upd_ready", 32'(upd_ready), 32'd1);
    endtask

    task automatic idle(input int n, input int y);
        for (int i = 0; i < n; i++) step(0, y, 1'b0);
    endtask

    initial begin
        reset = 1'b1; upd_valid = 1'b0; upd_square = '0; upd_piece = '0;
        sel_en = 1'b0; sel_square = '0; chk_en = 1'b0; chk_square = '0;
        m_reset();
        idle(3, 0);
        reset_checks();
        reset = 1'b0;

        step(111, 30, 1'b1);
        step(171, 30, 1'b1);
        step(140, 100, 1'b1);
        step(111, 30, 1'b0);
        step(80, 30, 1'b1);
        step(560, 30, 1'b1);
        step(561, 30, 1'b1);
        step(500, 450, 1'b1);
        step(111, 479, 1'b1);
        for (int i = 0; i < 12; i++)
            step(81 + $urandom_range(0, 479), $urandom_range(0, 479), 1'b1);
        idle(3, 0);

        upd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin upd_square = 6'd27; upd_piece = 4'd1; end
                1: begin upd_square = 6'd27; upd_piece = 4'd0; end
                2: begin upd_square = 6'd20; upd_piece = 4'd5; end
                default: begin upd_square = 6'd0; upd_piece = 4'd0; end
            endcase
            step(351, 100, 1'b1);
        end
        upd_valid = 1'b0;
        step(351, 150, 1'b1);
        step(111, 30, 1'b1);
        step(291, 210, 1'b1);
        idle(3, 0);

        sel_en = 1'b1; sel_square = 6'd36;
        chk_en = 1'b1; chk_square = 6'd60;
        idle(8, 480);
        sel_en = 1'b0; chk_en = 1'b0;

        step(291, 210, 1'b1);
        step(351, 150, 1'b1);
        step(111, 30, 1'b1);
        step(351, 270, 1'b1);
        step(323, 450, 1'b1);
        step(351, 450, 1'b1);
        step(351, 270, 1'b0);
        idle(3, 0);

        idle(3, 480);
        step(351, 270, 1'b1);
        step(323, 450, 1'b1);
        idle(3, 0);

        upd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            upd_square = 6'(i); upd_piece = 4'd0;
            step(200, 300, 1'b1);
        end
        upd_valid = 1'b0;
        idle(2, 480);
        reset = 1'b1;
        idle(2, 480);
        reset_checks();
        reset = 1'b0;
        idle(4, 480);
        step(111, 30, 1'b1);
        step(171, 30, 1'b1);
        step(231, 30, 1'b1);
        step(351, 150, 1'b1);
        idle(4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piece_draw_scheduler.md
# piece_draw_scheduler

Per-pixel scheduler for the chess board sprite datapath. It tracks which square the raster is in, holds the 64-square board state and sequences one shared 12-sprite ROM plus one palette for all piece types. CPU board updates are buffered and committed only during vertical blank, so a frame never shows a half-applied move. It sits between the VGA/HDMI timing generator and the pixel mux, and replaces the per-piece sprite modules.

## Interface
Parameters:
- SQ, 60: square edge in pixels, which is also the sprite edge.
- BOARD_X, 80: board left edge; square column c covers DrawX in (BOARD_X+SQ·c, BOARD_X+SQ·c+SQ].
- FIFO_DEPTH, 4: depth of the update FIFO, a power of 2.

Ports:
- vga_clk  in  1  pixel clock; the single clock domain.
- reset  in  1  synchronous, active-high reset.
- DrawX, DrawY  in  10 each  raster position. Square row r covers DrawY in [SQ·r, SQ·r+SQ).
- blank  in  1  1 = visible pixel.
- upd_valid, upd_ready  in/out  1 each  valid/ready handshake for board updates.
- upd_square  in  6  target square, {row, col}.
- upd_piece  in  4  piece code to write into the square.
- sel_en, sel_square  in  1, 6  selected-square highlight request.
- chk_en, chk_square  in  1, 6  checked-king border request.
- rom_addr  out  16  address to the shared sprite ROM. The ROM returns rom_q 1 cycle later.
- rom_q  in  4  palette index read from the ROM.
- pal_index  out  4  index to the combinational palette.
- pal_rgb  in  12  palette colour for pal_index.
- piece_on  out  1  this module owns the current output pixel.
- red, green, blue  out  4 each  output pixel colour.

## Operation
- Piece codes:
  - 0 = empty.
  - 1–6 = white P, N, B, R, Q, K.
  - 9–14 = black P, N, B, R, Q, K.
  - 7, 8 and 15 are treated as empty.
  - Sprite index = 6·code[3] + code[2:0] − 1, range 0..11.
- Pipeline stage S0 (register inputs):
  - In-board: DrawX in (80, 560] and DrawY in [0, 480).
  - Compute square {r, c}, local x lx = DrawX − 81 − 60c and local y ly = DrawY − 60r, both 0..59.
  - Read the board entry for the square.
- Pipeline stage S1: rom_addr = idx·3600 + ly·60 + lx. The maximum is 43199, which fits in 16 bits. Register the flags: occupied, selected, border, visible.
- Pipeline stage S2: rom_q is returned. Palette index 0 (pink) is transparent.
- Output priority, highest first:
  1. Border: chk square and (lx<5 or lx≥55 or ly<5 or ly≥55) → 12'hF00, piece_on=1.
  2. Occupied and rom_q≠0 → pal_rgb, piece_on=1.
  3. Selected square (occupied or not), transparent or empty pixel → 12'h6A6, piece_on=1.
  4. Otherwise piece_on=0 and rgb=0.
- piece_on is forced to 0 when blank=0 or the pixel is outside the board.
- Update FIFO:
  - upd_ready = !full.
  - A push occurs on a cycle with upd_valid && upd_ready.
  - Entries are applied in push order, so a later write to the same square wins.
- FSM states:
  - ACTIVE: in ACTIVE while DrawY<480; no board writes.
  - ACTIVE → DRAIN when DrawY≥480.
  - DRAIN: pops one entry per cycle and writes it to the board.
  - DRAIN → ACTIVE when DrawY<480. Remaining entries wait for the next vertical blank.
  - Push and pop in the same cycle are both performed, and occupancy is unchanged.
- sel_* and chk_* are sampled into shadow registers on the ACTIVE→DRAIN transition and used for the whole following frame.
- Reset:
  - The board loads the standard opening: row 0 = black back rank 12,10,11,13,14,11,10,12; row 1 = 9; rows 6 and 7 = white mirror of rows 1 and 0.
  - FIFO empties; all pending entries are discarded.
  - Shadow sel and chk flags are cleared.
  - FSM goes to ACTIVE.
  - piece_on, rgb and rom_addr are 0, and pal_index = 0.
  - upd_ready = 1 in the first cycle after reset deasserts.

## Timing
- Latency: piece_on and rgb are valid 3 vga_clk cycles after the DrawX/DrawY/blank they correspond to. The downstream mux delays its own inputs to match.
- pal_index = rom_q, combinational in S2. pal_rgb is consumed in the same cycle.
- A board write performed in DRAIN cycle k is visible in S0 from cycle k+1.
- A full FIFO holds upd_ready=0 until the first DRAIN pop.

## Configuration
- PIECE_CHECK_BORDER_EN:
  - Defined: chk_en/chk_square are sampled and the red border is drawn.
  - Undefined: chk_* inputs are ignored, the border logic and its shadow register are removed, and priority starts at the piece rule.

## Test plan
- Reset, then scan pixel (111,30), square {0,0} with lx=30, ly=30 → after 3 cycles rom_addr = 9·3600 + 30·60 + 30 = 34230 has been issued, and piece_on follows rom_q≠0.
- Push 4 updates while DrawY=100 → upd_ready=0 after the 4th push. The board is unchanged until DrawY=480, then 4 writes happen in consecutive cycles and upd_ready=1.
- Push square 27 ← 1, then square 27 ← 0, within one frame → after the blank, square 27 is empty.
- sel_en=1, sel_square=36 (empty), pixel inside square 36 → rgb 6A6 and piece_on=1. Setting sel_en=0 mid-frame → highlight persists until the next DRAIN.
- With PIECE_CHECK_BORDER_EN, chk_square=60, pixel with lx=2 → F00. With the macro undefined, the same pixel shows the piece's own colour.
- Assert reset during DRAIN with 2 entries pending → the FIFO is emptied, the board returns to the opening position, and outputs are 0.
